// File: rtl/comp_cfg_loader.sv
// ---------------------------------------------------------------------------
// comp_cfg_loader
//
// Purpose:
//   AXI4-Lite master that loads C_NUM_REGS 32-bit configuration words from
//   CFG_DATA into consecutive registers starting at C_BASE_ADDR. Each word is
//   written with one AW and one W beat, and the master then waits for the B
//   response. Optionally, each word is read back and compared.
//   A rising edge on INIT_AXI_TXN starts a load. The edge is only honoured
//   while the block is idle or done. TXN_DONE rises when the last word
//   completes. ERROR is sticky for the current load.
//
// Configuration:
//   CFG_LOADER_READBACK_EN - when defined, every write is followed by a read
//   of the same address. A non-OKAY RRESP or a data mismatch sets ERROR.
//   When the macro is undefined, the AR/R outputs are held at 0 and ERROR
//   reflects BRESP only.
//
// Ports:
//   M_AXI_ACLK / M_AXI_ARESETN  clock, asynchronous active-low reset
//   INIT_AXI_TXN                start request (rising edge)
//   CFG_DATA                    word i = CFG_DATA[32*i+31:32*i]
//   TXN_DONE, ERROR             load status
//   M_AXI_AW*, M_AXI_W*, M_AXI_B*  write channels
//   M_AXI_AR*, M_AXI_R*         read channels
// ---------------------------------------------------------------------------
module comp_cfg_loader #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_REGS         = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h0
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            INIT_AXI_TXN,
  input  logic [C_NUM_REGS*32-1:0]        CFG_DATA,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int IDX_W = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD,
    S_RD_RESP,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d, idx_nxt;
  logic                          init_q, init_d;
  logic                          awvalid_q, awvalid_d;
  logic                          wvalid_q, wvalid_d;
  logic                          aw_done_q, aw_done_d;
  logic                          w_done_q, w_done_d;
  logic                          bready_q, bready_d;
  logic                          txn_done_q, txn_done_d;
  logic                          error_q, error_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
`ifdef CFG_LOADER_READBACK_EN
  logic                          arvalid_q, arvalid_d;
  logic                          rready_q, rready_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
`else
  // The read channel inputs have no function without readback.
  logic unused_rd;
  assign unused_rd = &{1'b0, M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

  logic                          start;
  logic                          aw_hs;
  logic                          w_hs;
  logic [31:0]                   cfg_words [C_NUM_REGS];
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_cur;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_nxt;

  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_words
    assign cfg_words[k] = CFG_DATA[32*k +: 32];
  end

  assign idx_nxt  = idx_q + IDX_W'(1);
  assign addr_cur = C_BASE_ADDR + (C_M_AXI_ADDR_WIDTH'(idx_q) << 2);
  assign addr_nxt = C_BASE_ADDR + (C_M_AXI_ADDR_WIDTH'(idx_nxt) << 2);
  assign start    = INIT_AXI_TXN & ~init_q;
  assign aw_hs    = awvalid_q & M_AXI_AWREADY;
  assign w_hs     = wvalid_q & M_AXI_WREADY;

  // Next-state logic. AW/W VALIDs and the word's address/data are loaded on
  // the transition into S_WR. This way they are already valid in the first
  // S_WR cycle, and they hold steady until their own handshake.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    init_d     = INIT_AXI_TXN;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    bready_d   = bready_q;
    txn_done_d = txn_done_q;
    error_d    = error_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
`ifdef CFG_LOADER_READBACK_EN
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    araddr_d   = araddr_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_WR;
          idx_d      = '0;
          txn_done_d = 1'b0;
          error_d    = 1'b0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          awaddr_d   = C_BASE_ADDR;
          wdata_d    = C_M_AXI_DATA_WIDTH'(cfg_words[0]);
        end
      end

      S_WR: begin
        // AW and W finish independently. The "done" flags remember
        // whichever channel already completed.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end
      end

      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP != 2'b00) begin
            error_d = 1'b1;
          end
`ifdef CFG_LOADER_READBACK_EN
          state_d   = S_RD;
          arvalid_d = 1'b1;
          araddr_d  = addr_cur;
`else
          state_d   = S_NEXT;
`endif
        end
      end

`ifdef CFG_LOADER_READBACK_EN
      S_RD: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_RESP;
        end
      end

      S_RD_RESP: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          if ((M_AXI_RRESP != 2'b00) ||
              (M_AXI_RDATA != C_M_AXI_DATA_WIDTH'(cfg_words[idx_q]))) begin
            error_d = 1'b1;
          end
          state_d = S_NEXT;
        end
      end
`endif

      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d    = S_DONE;
          txn_done_d = 1'b1;
        end else begin
          state_d   = S_WR;
          idx_d     = idx_nxt;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = addr_nxt;
          wdata_d   = C_M_AXI_DATA_WIDTH'(cfg_words[idx_nxt]);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // All state and every registered output. Reset clears everything
  // immediately. The block then stays idle until the next start edge.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      init_q     <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      bready_q   <= 1'b0;
      txn_done_q <= 1'b0;
      error_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
`ifdef CFG_LOADER_READBACK_EN
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      araddr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      init_q     <= init_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      bready_q   <= bready_d;
      txn_done_q <= txn_done_d;
      error_q    <= error_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
`ifdef CFG_LOADER_READBACK_EN
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      araddr_q   <= araddr_d;
`endif
    end
  end

  assign TXN_DONE      = txn_done_q;
  assign ERROR         = error_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARPROT  = 3'b000;
`ifdef CFG_LOADER_READBACK_EN
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
`else
  assign M_AXI_ARADDR  = '0;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;
`endif

endmodule
